// File: rtl/jts16_layer_mix_pkg.sv
// Shared constants and helpers for the S16 layer aligner / priority mixer.
// Used by jts16_layer_mix (optional JTS16_LAYER_SOLO_EN build) and jts16_mix_dly.
package jts16_mix_pkg;

  localparam logic [3:0] TRANSP_MASK = 4'hf;
  localparam int         MAX_NL      = 8;
  localparam int         MAX_LW      = 3;

  function automatic logic is_opaque(input logic [3:0] col, input logic en);
    return en && ((col & TRANSP_MASK) != 4'h0);
  endfunction

  // Returns {opaque, layer id}; slots are scanned from 0, the first opaque layer wins.
  function automatic logic [MAX_LW:0] prio_pick(input logic [MAX_NL-1:0]        opq,
                                                input logic [MAX_NL*MAX_LW-1:0] slots,
                                                input int                       nl);
    logic              found;
    logic [MAX_LW-1:0] id;
    logic [MAX_LW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < MAX_NL; k++) begin
      id = slots[k*MAX_LW +: MAX_LW];
      if (!found && k < nl && int'(id) < nl && opq[id]) begin
        found = 1'b1;
        win   = id;
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/jts16_layer_mix_if.sv
// Pixel-path bundle between the layer generators, the mixer and the palette stage.
interface jts16_layer_mix_if #(
  parameter int NL   = 4,
  parameter int PW   = 11,
  parameter int DLYW = 5
);
  localparam int LW = $clog2(NL);

  logic               pxl_cen;
  logic               LHBL;
  logic               LVBL;
  logic [NL*PW-1:0]   layer_pxl;
  logic [NL-1:0]      layer_en;
  logic [NL*DLYW-1:0] layer_dly;
  logic [NL*LW-1:0]   prio_order;

  logic [PW-1:0]      pxl;
  logic [LW-1:0]      pxl_layer;
  logic               pxl_opaque;
  logic               LHBL_dly;
  logic               LVBL_dly;

  modport master (
    output pxl_cen, LHBL, LVBL, layer_pxl, layer_en, layer_dly, prio_order,
    input  pxl, pxl_layer, pxl_opaque, LHBL_dly, LVBL_dly
  );

  modport slave (
    input  pxl_cen, LHBL, LVBL, layer_pxl, layer_en, layer_dly, prio_order,
    output pxl, pxl_layer, pxl_opaque, LHBL_dly, LVBL_dly
  );
endinterface

// File: rtl/jts16_layer_mix_dly.sv
// One PW-wide circular delay line; the write pointer is shared and owned by the parent.
module jts16_mix_dly
  import jts16_mix_pkg::*;
#(
  parameter int PW   = 11,
  parameter int DLYW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pxl_cen,
  input  logic [DLYW-1:0] wp,
  input  logic [DLYW-1:0] dly,
  input  logic [PW-1:0]   din,
  output logic [PW-1:0]   dout
);
  localparam int DEPTH = 2**DLYW;

  logic [PW-1:0]   r_mem [DEPTH];
  logic [DLYW-1:0] w_raddr;

  assign w_raddr = wp - dly;

  always_ff @(posedge clk) begin
    if (rst_n && pxl_cen) r_mem[wp] <= din;
  end

  // A zero delay must return this pixel, which is not in the array until the edge.
  assign dout = (dly == '0) ? din : r_mem[w_raddr];

endmodule

// File: rtl/jts16_layer_mix.sv
// Layer aligner and priority mixer: per-layer delay compensation, then a programmable priority pick.
// Optional JTS16_LAYER_SOLO_EN adds debug_bus to show a single layer.
module jts16_layer_mix
  import jts16_mix_pkg::*;
#(
  parameter int NL   = 4,
  parameter int PW   = 11,
  parameter int DLYW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  jts16_layer_mix_if.slave   mix
`ifdef JTS16_LAYER_SOLO_EN
  , input  logic [7:0]       debug_bus
`endif
);
  localparam int LW = $clog2(NL);

  logic [DLYW-1:0]          r_wp;
  logic [DLYW:0]            r_prime;
  logic                     r_lvbl_last;
  logic [NL*DLYW-1:0]       r_dly_sh;
  logic [NL*LW-1:0]         r_prio_sh;

  logic [PW-1:0]            w_dout [NL];
  logic [NL-1:0]            w_opq_p0;
  logic                     w_vb_fall;

  logic [PW-1:0]            r_pxl_p1 [NL];
  logic [NL-1:0]            r_opq_p1;
  logic                     r_hb_p1;
  logic                     r_vb_p1;

  logic [MAX_NL*MAX_LW-1:0] w_slots;
  logic [MAX_LW:0]          w_pick;
  logic [PW-1:0]            w_win_pxl;
  logic                     w_show;

  logic [PW-1:0]            r_pxl_p2;
  logic [LW-1:0]            r_layer_p2;
  logic                     r_opq_p2;
  logic                     r_hb_p2;
  logic                     r_vb_p2;

  assign w_vb_fall = r_lvbl_last & ~mix.LVBL;

  for (genvar gi = 0; gi < NL; gi++) begin : g_dly
    jts16_mix_dly #(
      .PW   (PW),
      .DLYW (DLYW)
    ) u_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .pxl_cen (mix.pxl_cen),
      .wp      (r_wp),
      .dly     (r_dly_sh[gi*DLYW +: DLYW]),
      .din     (mix.layer_pxl[gi*PW +: PW]),
      .dout    (w_dout[gi])
    );
  end

  // Stage 0 -> 1: delayed read, transparency/enable mask, stale-buffer priming mask
  always_comb begin
    w_opq_p0 = '0;
    for (int i = 0; i < NL; i++) begin
      w_opq_p0[i] = r_prime[DLYW] && is_opaque(w_dout[i][3:0], mix.layer_en[i]);
`ifdef JTS16_LAYER_SOLO_EN
      if (debug_bus[7] && (debug_bus[LW-1:0] != LW'(i))) w_opq_p0[i] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mix.pxl_cen) begin
      for (int i = 0; i < NL; i++) r_pxl_p1[i] <= w_dout[i];
    end
  end

  // Stage 1 -> 2: priority select and blanking
  always_comb begin
    w_slots = '0;
    for (int k = 0; k < NL; k++) begin
      w_slots[k*MAX_LW +: MAX_LW] = MAX_LW'(r_prio_sh[k*LW +: LW]);
    end
  end

  assign w_pick = prio_pick(MAX_NL'(r_opq_p1), w_slots, NL);
  assign w_show = r_hb_p1 & r_vb_p1 & w_pick[MAX_LW];

  always_comb begin
    w_win_pxl = '0;
    for (int i = 0; i < NL; i++) begin
      if (w_pick[MAX_LW-1:0] == MAX_LW'(i)) w_win_pxl = r_pxl_p1[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_prime     <= '0;
      r_lvbl_last <= 1'b0;
      r_dly_sh    <= mix.layer_dly;
      r_prio_sh   <= mix.prio_order;
      r_opq_p1    <= '0;
      r_hb_p1     <= 1'b0;
      r_vb_p1     <= 1'b0;
      r_pxl_p2    <= '0;
      r_layer_p2  <= '0;
      r_opq_p2    <= 1'b0;
      r_hb_p2     <= 1'b0;
      r_vb_p2     <= 1'b0;
    end else if (mix.pxl_cen) begin
      r_wp        <= r_wp + 1'b1;
      if (!r_prime[DLYW]) r_prime <= r_prime + 1'b1;
      r_lvbl_last <= mix.LVBL;
      // Mid-frame register writes only become visible at the start of vblank.
      if (w_vb_fall) begin
        r_dly_sh  <= mix.layer_dly;
        r_prio_sh <= mix.prio_order;
      end
      r_opq_p1    <= w_opq_p0;
      r_hb_p1     <= mix.LHBL;
      r_vb_p1     <= mix.LVBL;
      r_pxl_p2    <= w_show ? w_win_pxl : '0;
      r_layer_p2  <= w_show ? w_pick[LW-1:0] : '0;
      r_opq_p2    <= w_show;
      r_hb_p2     <= r_hb_p1;
      r_vb_p2     <= r_vb_p1;
    end
  end

  assign mix.pxl        = r_pxl_p2;
  assign mix.pxl_layer  = r_layer_p2;
  assign mix.pxl_opaque = r_opq_p2;
  assign mix.LHBL_dly   = r_hb_p2;
  assign mix.LVBL_dly   = r_vb_p2;

endmodule

// File: tb/tb_jts16_layer_mix.sv
// Bench for jts16_layer_mix: hand-built vector table, directed corner sequences and a random run
// checked against a history-based reference model.
module tb_jts16_layer_mix;
  localparam int NL    = 4;
  localparam int PW    = 11;
  localparam int DLYW  = 5;
  localparam int LW    = 2;
  localparam int DEPTH = 32;
  localparam int MAXC  = 2048;
  localparam int OW    = PW + LW + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] dbg = 8'h00;

  jts16_layer_mix_if #(.NL(NL), .PW(PW), .DLYW(DLYW)) mif ();

  jts16_layer_mix #(.NL(NL), .PW(PW), .DLYW(DLYW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mix   (mif)
`ifdef JTS16_LAYER_SOLO_EN
    , .debug_bus (dbg)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int ncen   = 0;

  logic [NL*PW-1:0]   h_pxl  [MAXC];
  logic [NL-1:0]      h_en   [MAXC];
  logic               h_hb   [MAXC];
  logic               h_vb   [MAXC];
  logic [7:0]         h_dbg  [MAXC];
  logic [NL*DLYW-1:0] h_dly  [MAXC];
  logic [NL*LW-1:0]   h_prio [MAXC];
  logic [NL*DLYW-1:0] m_dly;
  logic [NL*LW-1:0]   m_prio;
  logic               m_lv_prev;

  typedef struct {
    logic [NL*PW-1:0] px;
    logic [NL-1:0]    en;
    logic [NL*LW-1:0] prio;
    logic [OW-1:0]    exp;
  } vec_t;

  function automatic logic [7:0] solo_val();
`ifdef JTS16_LAYER_SOLO_EN
    return dbg;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [NL*LW-1:0] pr(input int a, input int b, input int c, input int d);
    logic [1:0] s0, s1, s2, s3;
    s0 = a[1:0]; s1 = b[1:0]; s2 = c[1:0]; s3 = d[1:0];
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [OW-1:0] ov(input logic [PW-1:0] p, input int l, input logic o,
                                       input logic hb, input logic vb);
    logic [LW-1:0] lid;
    lid = LW'(l);
    return {p, lid, o, hb, vb};
  endfunction

  function automatic logic [PW-1:0] ramp(input int i, input int c);
    logic [6:0] hi;
    logic [3:0] lo;
    hi = 7'(c);
    lo = 4'(i + 1);
    return {hi, lo};
  endfunction

  // Output seen after the pxl_cen with index c (counted from reset release).
  function automatic logic [OW-1:0] model(input int c);
    logic [NL-1:0] opq;
    logic [PW-1:0] p;
    logic [OW-1:0] r;
    logic          found;
    int s, src, id;
    if (c < 1) return '0;
    s   = c - 1;
    opq = '0;
    if (s >= DEPTH) begin
      for (int i = 0; i < NL; i++) begin
        src    = s - int'(h_dly[s][i*DLYW +: DLYW]);
        p      = h_pxl[src][i*PW +: PW];
        opq[i] = h_en[s][i] && (p[3:0] != 4'h0) &&
                 (!h_dbg[s][7] || int'(h_dbg[s][LW-1:0]) == i);
      end
    end
    r     = ov('0, 0, 1'b0, h_hb[s], h_vb[s]);
    found = 1'b0;
    if (h_hb[s] && h_vb[s]) begin
      for (int k = 0; k < NL; k++) begin
        id = int'(h_prio[c][k*LW +: LW]);
        if (!found && id < NL && opq[id]) begin
          found = 1'b1;
          src   = s - int'(h_dly[s][id*DLYW +: DLYW]);
          r     = ov(h_pxl[src][id*PW +: PW], id, 1'b1, 1'b1, 1'b1);
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] exp_v);
    logic [OW-1:0] act;
    act = {mif.pxl, mif.pxl_layer, mif.pxl_opaque, mif.LHBL_dly, mif.LVBL_dly};
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cen %0d: got pxl=%h layer=%0d opq=%0b hb=%0b vb=%0b, want pxl=%h layer=%0d opq=%0b hb=%0b vb=%0b",
               nm, ncen, act[OW-1 -: PW], act[LW+2 -: LW], act[2], act[1], act[0],
               exp_v[OW-1 -: PW], exp_v[LW+2 -: LW], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic tick(input logic cen);
    logic adv;
    mif.pxl_cen = cen;
    adv = cen && rst_n;
    if (!rst_n) begin
      ncen      = 0;
      m_dly     = mif.layer_dly;
      m_prio    = mif.prio_order;
      m_lv_prev = 1'b0;
    end else if (adv) begin
      if (ncen >= MAXC) begin
        $display("FAIL history overflow: got %0d cens, limit %0d", ncen, MAXC);
        $fatal(1);
      end
      h_pxl[ncen]  = mif.layer_pxl;
      h_en[ncen]   = mif.layer_en;
      h_hb[ncen]   = mif.LHBL;
      h_vb[ncen]   = mif.LVBL;
      h_dbg[ncen]  = solo_val();
      h_dly[ncen]  = m_dly;
      h_prio[ncen] = m_prio;
      if (m_lv_prev && !mif.LVBL) begin
        m_dly  = mif.layer_dly;
        m_prio = mif.prio_order;
      end
      m_lv_prev = mif.LVBL;
    end
    @(posedge clk);
    #1;
    if (adv) ncen++;
  endtask

  task automatic step(input logic cen, input string nm);
    tick(cen);
    chk(nm, rst_n ? model(ncen - 1) : '0);
  endtask

  task automatic vblank_load();
    mif.LVBL = 1'b0;
    tick(1'b1);
    mif.LVBL = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   dl  [4];
    int   s, vb_cnt;
    logic [PW-1:0] p;

    tbl[0] = '{ {11'h000, 11'h345, 11'h123, 11'h010}, 4'hf, pr(0,2,1,3), ov(11'h345, 2, 1'b1, 1'b1, 1'b1) };
    tbl[1] = '{ {11'h000, 11'h7f0, 11'h020, 11'h010}, 4'hf, pr(0,1,2,3), ov(11'h000, 0, 1'b0, 1'b1, 1'b1) };
    tbl[2] = '{ {11'h444, 11'h333, 11'h120, 11'h111}, 4'hf, pr(1,1,0,3), ov(11'h111, 0, 1'b1, 1'b1, 1'b1) };
    tbl[3] = '{ {11'h444, 11'h333, 11'h222, 11'h111}, 4'hc, pr(0,1,2,3), ov(11'h333, 2, 1'b1, 1'b1, 1'b1) };
    tbl[4] = '{ {11'h444, 11'h333, 11'h220, 11'h111}, 4'hf, pr(1,1,1,1), ov(11'h000, 0, 1'b0, 1'b1, 1'b1) };
    tbl[5] = '{ {11'h440, 11'h333, 11'h222, 11'h111}, 4'hf, pr(3,2,1,0), ov(11'h333, 2, 1'b1, 1'b1, 1'b1) };
    tbl[6] = '{ {11'h444, 11'h333, 11'h222, 11'h7ff}, 4'hf, pr(0,1,2,3), ov(11'h7ff, 0, 1'b1, 1'b1, 1'b1) };
    dl = '{0, 3, 7, 31};

    mif.pxl_cen    = 1'b0;
    mif.LHBL       = 1'b1;
    mif.LVBL       = 1'b1;
    mif.layer_pxl  = {11'h000, 11'h000, 11'h000, 11'h123};
    mif.layer_en   = 4'hf;
    mif.layer_dly  = '0;
    mif.prio_order = pr(0,1,2,3);

    // Reset with pxl_cen toggling, then priming window
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) step(k[0], "reset_state");
    rst_n = 1'b1;
    step(1'b0, "hold_no_cen");
    for (int k = 1; k <= 33; k++) begin
      tick(1'b1);
      n_cmp++;
      if (mif.pxl_opaque !== 1'b0) begin
        n_fail++;
        $display("FAIL prime cen %0d: got opaque=%0b want 0", k, mif.pxl_opaque);
      end
    end
    tick(1'b1);
    chk("prime_end", ov(11'h123, 0, 1'b1, 1'b1, 1'b1));

    // Delay compensation: one layer enabled at a time, ramp data
    mif.layer_dly = {5'd31, 5'd7, 5'd3, 5'd0};
    rst_n = 1'b0;
    step(1'b1, "reset_state");
    step(1'b1, "reset_state");
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NL; i++) mif.layer_pxl[i*PW +: PW] = ramp(i, c);
      mif.layer_en = 4'(1 << (c / 50));
      tick(1'b1);
      s = c - 1;
      if (s >= DEPTH) chk("delay", ov(ramp(s / 50, s - dl[s / 50]), s / 50, 1'b1, 1'b1, 1'b1));
    end

    // Priority table, each row's order loaded at a vblank start
    mif.layer_dly = '0;
    mif.layer_en  = 4'hf;
    rst_n = 1'b0;
    step(1'b1, "reset_state");
    rst_n = 1'b1;
    for (int k = 0; k < 34; k++) tick(1'b1);
    for (int r = 0; r < 7; r++) begin
      mif.prio_order = tbl[r].prio;
      mif.layer_pxl  = tbl[r].px;
      mif.layer_en   = tbl[r].en;
      vblank_load();
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      chk($sformatf("prio_row%0d", r), tbl[r].exp);
    end

    // Mid-frame priority change waits for vblank
    mif.layer_pxl = {11'h000, 11'h000, 11'h222, 11'h111};
    mif.layer_en  = 4'hf;
    for (int k = 0; k < 3; k++) tick(1'b1);
    chk("shadow_before", ov(11'h111, 0, 1'b1, 1'b1, 1'b1));
    mif.prio_order = pr(1,0,2,3);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1);
      chk("shadow_hold", ov(11'h111, 0, 1'b1, 1'b1, 1'b1));
    end
    mif.LVBL = 1'b0;
    tick(1'b1);
    chk("shadow_fall", ov(11'h111, 0, 1'b1, 1'b1, 1'b1));
    mif.LVBL = 1'b1;
    tick(1'b1);
    chk("vblank_out", ov(11'h000, 0, 1'b0, 1'b1, 1'b0));
    tick(1'b1);
    chk("shadow_new", ov(11'h222, 1, 1'b1, 1'b1, 1'b1));

    // Horizontal blank forces backdrop two pixels later
    mif.LHBL = 1'b0;
    tick(1'b1);
    chk("hblank_pre", ov(11'h222, 1, 1'b1, 1'b1, 1'b1));
    mif.LHBL = 1'b1;
    tick(1'b1);
    chk("hblank", ov(11'h000, 0, 1'b0, 1'b0, 1'b1));
    tick(1'b1);
    chk("hblank_post", ov(11'h222, 1, 1'b1, 1'b1, 1'b1));

`ifdef JTS16_LAYER_SOLO_EN
    mif.layer_pxl  = {11'h444, 11'h333, 11'h222, 11'h111};
    mif.prio_order = pr(0,1,2,3);
    dbg = 8'h82;
    vblank_load();
    for (int k = 0; k < 3; k++) tick(1'b1);
    chk("solo_on", ov(11'h333, 2, 1'b1, 1'b1, 1'b1));
    dbg = 8'h02;
    tick(1'b1);
    chk("solo_latency", ov(11'h333, 2, 1'b1, 1'b1, 1'b1));
    tick(1'b1);
    chk("solo_off", ov(11'h111, 0, 1'b1, 1'b1, 1'b1));
`endif

    // Random runs against the reference model; each starts with a mid-frame reset
    for (int run = 0; run < 2; run++) begin
      mif.layer_dly  = 20'($urandom);
      mif.prio_order = 8'($urandom);
      mif.LVBL       = 1'b1;
      rst_n = 1'b0;
      step(1'b1, "reset_state");
      mif.LVBL = 1'b0;
      step(1'b1, "reset_state");
      rst_n  = 1'b1;
      vb_cnt = 2;
      for (int it = 0; it < 700; it++) begin
        if ($urandom_range(99) < 5) mif.prio_order = 8'($urandom);
        if ($urandom_range(99) < 5) mif.layer_dly  = 20'($urandom);
        for (int i = 0; i < NL; i++) begin
          p = 11'($urandom);
          if ($urandom_range(99) < 25) p[3:0] = 4'h0;
          mif.layer_pxl[i*PW +: PW] = p;
          mif.layer_en[i] = ($urandom_range(99) < 85);
        end
        mif.LHBL = ($urandom_range(99) >= 10);
        if (vb_cnt == 0 && $urandom_range(99) < 3) vb_cnt = $urandom_range(1, 4);
        mif.LVBL = (vb_cnt == 0);
        if (vb_cnt > 0) vb_cnt--;
        dbg = ($urandom_range(99) < 15) ? {1'b1, 7'($urandom)} : 8'($urandom_range(127));
        step($urandom_range(99) >= 20, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
